// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses FIRST_REG..LAST_REG on one read port and streams
// the captured {address, data} pairs over a valid/ready handshake for the trace path.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rn_o,
  input  logic [DATA_W-1:0] rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  state_e              state_q;
  logic [ADDR_W-1:0]   rn_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  logic                handshake;
  logic                last_beat;
  logic [ADDR_W-1:0]   rn_inc_d;

  assign handshake = valid_q & out_ready_i;
  assign last_beat = (rn_q == LAST_A);
  assign rn_inc_d  = rn_q + 1'b1;

  // Abort outranks every state transition, including a Start seen in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rn_q       <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      rn_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rn_q   <= '0;
          done_q <= 1'b0;
          if (start_i) begin
            rn_q    <= FIRST_A;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        // Read data is captured here so later register writes cannot disturb the beat.
        S_READ: begin
          out_data_q <= rd_i;
          out_addr_q <= rn_q;
          valid_q    <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (last_beat) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rn_q    <= rn_inc_d;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          rn_q    <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rn_o        = rn_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file model feeds the read port,
// expected beats are queued at Start and compared as the DUT presents them.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [4:0]  rn;
  logic [31:0] rd;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy, done;

  logic        start1, ready1;
  logic [4:0]  rn1;
  logic [31:0] rd1;
  logic        valid1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic        busy1, done1;

  logic [31:0] regs [32];
  logic [36:0] sb_q [$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_vld_cyc = -1;
  int t0 = 0;
  int ready_mode = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd  = regs[rn];
  assign rd1 = regs[rn1];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .rn_o(rn), .rd_i(rd), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_data_o(out_data), .busy_o(busy), .done_o(done)
  );

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(4), .LAST_REG(4)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(1'b0),
    .rn_o(rn1), .rd_i(rd1), .out_valid_o(valid1), .out_ready_i(ready1),
    .out_addr_o(addr1), .out_data_o(data1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Sink ready: always high, or held low for 5 cycles of each beat.
  always @(negedge clk) begin
    #1;
    if (ready_mode == 0) begin
      out_ready = 1'b1;
    end else if (out_valid) begin
      if (wait_cnt >= 5) out_ready = 1'b1;
      else begin
        out_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      out_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: sampled 2 ns before each posedge, so a handshake here happens at that edge.
  always @(negedge clk) begin
    #3;
    if (rst_n && !abort) begin
      if (out_valid) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (sb_q.size() == 0) chk("extra_beat", 64'(out_addr), 64'hFFFF);
        else begin
          chk("beat_addr", 64'(out_addr), 64'(sb_q[0][36:32]));
          chk("beat_data", 64'(out_data), 64'(sb_q[0][31:0]));
          if (out_ready) begin
            void'(sb_q.pop_front());
            beats++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_all();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = i[4:0];
      sb_q.push_back({a, regs[i]});
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_addr(input logic [4:0] a);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_addr == a) hit = 1'b1;
    end
    chk("wait_addr_reached", 64'(hit), 64'd1);
  endtask

  task automatic wait_idle(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'(target));
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    chk("beat_count", 64'(beats), 64'd32);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic clear_run();
    beats = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_vld_cyc = -1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_rn"}, 64'(rn), 64'd0);
    chk({pfx, "_addr"}, 64'(out_addr), 64'd0);
    chk({pfx, "_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start1 = 1'b0;
    ready1 = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Full dump with a sink that is always ready; check cycle timing.
    clear_run();
    push_all();
    start_pulse();
    wait_idle(1);
    chk("first_valid_latency", 64'(first_vld_cyc - t0), 64'd1);
    chk("done_latency", 64'(done_cyc - t0), 64'd64);

    // Back-pressured sink; data must stay on the front of the queue while stalled.
    ready_mode = 1;
    clear_run();
    push_all();
    start_pulse();
    wait_idle(1);
    ready_mode = 0;

    // A second Start mid-dump is ignored.
    clear_run();
    push_all();
    start_pulse();
    wait_addr(5'd10);
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_idle(1);

    // Abort while beat 7 is held, then restart from address 0.
    clear_run();
    push_all();
    start_pulse();
    wait_addr(5'd7);
    abort = 1'b1;
    @(negedge clk); #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rn", 64'(rn), 64'd0);
    abort = 1'b0;
    sb_q.delete();
    repeat (80) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    clear_run();
    push_all();
    start_pulse();
    wait_idle(1);

    // Register writes during the dump: ahead of the pointer visible, behind it not.
    clear_run();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = i[4:0];
      sb_q.push_back({a, (i == 20) ? 32'hDEADBEEF : regs[i]});
    end
    start_pulse();
    wait_addr(5'd5);
    regs[20] = 32'hDEADBEEF;
    regs[3]  = 32'h12345678;
    wait_idle(1);
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;

    // Asynchronous reset in the middle of a dump.
    clear_run();
    push_all();
    start_pulse();
    wait_addr(5'd12);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;

    // Single-register dump on the FIRST=LAST=4 instance.
    @(negedge clk); #1 start1 = 1'b1;
    @(negedge clk); #1 start1 = 1'b0;
    chk("one_busy", 64'(busy1), 64'd1);
    @(negedge clk); #1;
    chk("one_valid", 64'(valid1), 64'd1);
    chk("one_addr", 64'(addr1), 64'd4);
    chk("one_data", 64'(data1), 64'h04040404);
    @(negedge clk); #1;
    chk("one_valid_after", 64'(valid1), 64'd0);
    chk("one_done", 64'(done1), 64'd1);
    chk("one_busy_after", 64'(busy1), 64'd0);
    @(negedge clk); #1;
    chk("one_done_pulse", 64'(done1), 64'd0);
    chk("one_rn_idle", 64'(rn1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
